dmem_resp: RTL

Data-memory responder for the memory/writeback stage's request port. Accepts a held-high request with address, write data and write enable, performs a single access on a synchronous single-port data SRAM after a configurable number of wait states, and returns a one-cycle acknowledge with read data. Sits between the core's data-memory port and the SRAM macro, which is instantiated outside this block.

---
 rtl/dmem_resp_pkg.sv | 19 +
 rtl/dmem_resp.sv | 105 ++++++++++
 2 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and width defaults for the data-memory responder.
package dmem_resp_pkg;

  localparam int unsigned DMEM_RW = 16;
  localparam int unsigned DMEM_AW = 12;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } dmem_state_e;

  // Wait-counter width: clog2(wait_cycles+1), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/dmem_resp.sv
// Data-memory responder: one SRAM access per held request, acked after WAIT_CYCLES.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag/drop accesses above the SRAM.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned RW          = DMEM_RW,
  parameter int unsigned AW          = DMEM_AW,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_mem_req,
  input  logic [RW-1:0] i_mem_addr,
  input  logic [RW-1:0] i_mem_data,
  input  logic          i_mem_we,
  output logic          o_mem_ack,
  output logic [RW-1:0] o_mem_data,
  output logic          o_mem_err,
  output logic          o_sram_en,
  output logic          o_sram_we,
  output logic [AW-1:0] o_sram_addr,
  output logic [RW-1:0] o_sram_wdata,
  input  logic [RW-1:0] i_sram_rdata
);

  localparam int unsigned    CW       = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] addr_q;
  logic [RW-1:0] data_q;
  logic          we_q;
  logic          oor;

`ifdef DMEM_RANGE_CHECK_EN
  assign oor = (addr_q >> AW) != '0;
`else
  logic unused_hi;
  assign oor       = 1'b0;
  assign unused_hi = |(addr_q >> AW);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request is captured only in IDLE, so the still-high req of an acking transfer is ignored.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && i_mem_req) begin
        addr_q <= i_mem_addr;
        data_q <= i_mem_data;
        we_q   <= i_mem_we;
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_mem_req) state_d = ISSUE;
      ISSUE:   state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
      WAIT:    if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe is gated by reset so an asserted reset never lets a write reach the SRAM.
  always_comb begin
    o_sram_en  = 1'b0;
    o_mem_ack  = 1'b0;
    o_mem_err  = 1'b0;
    o_mem_data = '0;
    unique case (state_q)
      ISSUE: o_sram_en = i_rst_n && !oor;
      ACK: begin
        o_mem_ack = 1'b1;
        o_mem_err = oor;
        if (!we_q && !oor) o_mem_data = i_sram_rdata;
      end
      default: ;
    endcase
  end

  assign o_sram_we    = o_sram_en && we_q;
  assign o_sram_addr  = addr_q[AW-1:0];
  assign o_sram_wdata = data_q;

endmodule
